id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic.
- Sits directly upstream of the ALU in the 5-stage MIPS pipeline and drives the ALU's A, B and 3-bit ALUOp inputs.
- Latches decoded operands and control each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Inserts a bubble on load-use hazards and counts the bubbles it inserts.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.
- CW, 16, bubble-counter width.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- hold  in  1  global freeze (memory wait): stage keeps contents.
- flush  in  1  kill the instruction entering EX (branch taken).
- id_valid  in  1  decode slot holds a real instruction.
- id_rs, id_rt, id_rd  in  RW each  decode register addresses.
- id_rs_data, id_rt_data  in  DW each  register-file read data.
- id_imm  in  DW  extended immediate.
- id_sa  in  5  shift amount.
- id_ALUSrcA  in  1  1: A = zero-extended sa.
- id_ALUSrcB  in  1  1: B = immediate.
- id_ALUOp  in  3  ALU operation code.
- id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_RegDst  in  1 each  decode control.
- exm_RegWrite  in  1  EX/MEM write enable.
- exm_rd  in  RW  EX/MEM destination.
- exm_result  in  DW  EX/MEM ALU result.
- mwb_RegWrite  in  1  MEM/WB write enable.
- mwb_rd  in  RW  MEM/WB destination.
- mwb_data  in  DW  MEM/WB writeback data.
- A, B  out  DW each  ALU operands.
- ALUOp  out  3  ALU operation.
- store_data  out  DW  forwarded rt value for stores.
- ex_dst  out  RW  destination register.
- ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg  out  1 each  pipelined control.
- load_use_stall  out  1  tells PC and IF/ID to hold.
- bubble_count  out  CW  saturating count of inserted bubbles.

Behaviour:
- Register update on rising CLK. Priority: Reset > flush > hold > load_use_stall > load.
- Reset:
  - All registered fields go to 0: valid, control, ALUOp=000, data, addresses.
  - bubble_count=0.
  - Outputs after reset: A=B=store_data=0, ex_dst=0, load_use_stall=0.
- flush: loads a bubble (valid and all control bits 0, ALUOp=000, data fields 0) even if hold=1. bubble_count is not incremented.
- hold (no flush): every register, including bubble_count, keeps its value.
- load_use_stall=1 (no hold/flush): loads a bubble and bubble_count increments. It saturates at all-ones.
- Otherwise: all id_* inputs are captured. A captured id_valid=0 forces all control bits to 0.
- load_use_stall is combinational from registered state and decode inputs. It is 1 when all of the following hold:
  - ex_valid & ex_MemRead;
  - captured rt != 0;
  - captured rt == id_rs, or captured rt == id_rt;
  - id_valid=1.
- Forwarding is combinational on the registered rs/rt. For each operand:
  - If exm_RegWrite, exm_rd != 0 and exm_rd == reg, use exm_result.
  - Else if the same test passes against mwb_RegWrite/mwb_rd, use mwb_data.
  - Else use the registered register-file data.
  - EX/MEM always has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand and output selection:
  - A = ALUSrcA_q ? {zero-fill, sa_q} : fwd_rs.
  - B = ALUSrcB_q ? imm_q : fwd_rt.
  - store_data = fwd_rt always, independent of ALUSrcB.
  - ex_dst = RegDst_q ? rd_q : rt_q.
- Latency: decode inputs appear on A/B/ALUOp one cycle after capture. Forwarding paths have 0 cycles of latency.
- Back-to-back load-use: at most one bubble per load, because the bubble clears ex_MemRead next cycle.
- hold while load_use_stall=1: stage frozen, stall stays asserted, and the count does not increment.
- Reset asserted mid-hold or mid-stall: Reset wins and all state clears in that cycle.

Test Plan:
- Reset: hold Reset 2 cycles with arbitrary inputs -> all outputs 0 and bubble_count=0 on the first post-reset cycle.
- Plain capture: id_rs_data=5, id_rt_data=3, ALUOp=001, both Src=0, no forwarding -> next cycle A=5, B=3, ALUOp=001.
- Forward priority: captured rs=8; exm_rd=8, exm_result=0xAAAA; mwb_rd=8, mwb_data=0x5555; both RegWrite=1 -> A=0xAAAA. Drop exm_RegWrite -> A=0x5555. Set exm_rd=0 -> A=registered data.
- Load-use: lw into $9 captured; id_rs=9 -> load_use_stall=1. Next cycle ex_valid=0, bubble_count=1, stall=0. Repeat with hold=1 during the stall -> contents and count unchanged.
- Flush vs hold: flush=1 and hold=1 together with a valid instruction in EX -> next cycle ex_valid=0, ex_RegWrite=0, bubble_count unchanged.
- Immediate/shift: ALUSrcA=1, sa=4, ALUSrcB=1, imm=0xFFFFFFF0, rt forwarded from exm=7 -> A=4, B=0xFFFFFFF0, store_data=7.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
// and load-use bubble insertion feeding the ALU.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          hold,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_sa,
   input  logic          id_ALUSrcA,
   input  logic          id_ALUSrcB,
   input  logic [2:0]    id_ALUOp,
   input  logic          id_RegWrite,
   input  logic          id_MemRead,
   input  logic          id_MemWrite,
   input  logic          id_MemToReg,
   input  logic          id_RegDst,
   input  logic          exm_RegWrite,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_result,
   input  logic          mwb_RegWrite,
   input  logic [RW-1:0] mwb_rd,
   input  logic [DW-1:0] mwb_data,
   output logic [DW-1:0] A,
   output logic [DW-1:0] B,
   output logic [2:0]    ALUOp,
   output logic [DW-1:0] store_data,
   output logic [RW-1:0] ex_dst,
   output logic          ex_valid,
   output logic          ex_RegWrite,
   output logic          ex_MemRead,
   output logic          ex_MemWrite,
   output logic          ex_MemToReg,
   output logic          load_use_stall,
   output logic [CW-1:0] bubble_count
);

   typedef struct packed {
      logic          valid;
      logic          regwrite;
      logic          memread;
      logic          memwrite;
      logic          memtoreg;
      logic          regdst;
      logic          srca;
      logic          srcb;
      logic [2:0]    aluop;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] rd;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm;
      logic [4:0]    sa;
   } id_ex_t;

   id_ex_t q;
   id_ex_t d;

   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;
   logic          rt_hit;

   always_comb begin
      d          = '0;
      d.valid    = id_valid;
      d.regwrite = id_valid & id_RegWrite;
      d.memread  = id_valid & id_MemRead;
      d.memwrite = id_valid & id_MemWrite;
      d.memtoreg = id_valid & id_MemToReg;
      d.regdst   = id_valid & id_RegDst;
      d.srca     = id_ALUSrcA;
      d.srcb     = id_ALUSrcB;
      d.aluop    = id_ALUOp;
      d.rs       = id_rs;
      d.rt       = id_rt;
      d.rd       = id_rd;
      d.rs_data  = id_rs_data;
      d.rt_data  = id_rt_data;
      d.imm      = id_imm;
      d.sa       = id_sa;
   end

   // Stall only when the load in EX feeds a real instruction in ID.
   always_comb begin
      rt_hit = (q.rt == id_rs) | (q.rt == id_rt);
      load_use_stall = q.valid & q.memread & (q.rt != '0)
                     & rt_hit & id_valid;
   end

   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] r,
      input logic [DW-1:0] rf
   );
      logic exm_hit;
      logic mwb_hit;
      exm_hit = exm_RegWrite & (exm_rd != '0) & (exm_rd == r);
      mwb_hit = mwb_RegWrite & (mwb_rd != '0) & (mwb_rd == r);
      if (exm_hit)      fwd = exm_result;
      else if (mwb_hit) fwd = mwb_data;
      else              fwd = rf;
   endfunction

   always_comb begin
      fwd_rs = fwd(q.rs, q.rs_data);
      fwd_rt = fwd(q.rt, q.rt_data);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         q            <= '0;
         bubble_count <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (hold) begin
         q            <= q;
         bubble_count <= bubble_count;
      end else if (load_use_stall) begin
         q <= '0;
         if (bubble_count != '1)
            bubble_count <= bubble_count + CW'(1);
      end else begin
         q <= d;
      end
   end

   always_comb begin
      A           = q.srca ? {{(DW-5){1'b0}}, q.sa} : fwd_rs;
      B           = q.srcb ? q.imm : fwd_rt;
      store_data  = fwd_rt;
      ALUOp       = q.aluop;
      ex_dst      = q.regdst ? q.rd : q.rt;
      ex_valid    = q.valid;
      ex_RegWrite = q.regwrite;
      ex_MemRead  = q.memread;
      ex_MemWrite = q.memwrite;
      ex_MemToReg = q.memtoreg;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding,
// load-use bubbles, flush/hold priority and counter saturation.
module tb_id_ex_stage;

   localparam int DW  = 32;
   localparam int RW  = 5;
   localparam int TCW = 2;

   logic          CLK = 1'b0;
   logic          Reset, hold, flush, id_valid;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]    id_sa;
   logic          id_ALUSrcA, id_ALUSrcB;
   logic [2:0]    id_ALUOp;
   logic          id_RegWrite, id_MemRead, id_MemWrite;
   logic          id_MemToReg, id_RegDst;
   logic          exm_RegWrite, mwb_RegWrite;
   logic [RW-1:0] exm_rd, mwb_rd;
   logic [DW-1:0] exm_result, mwb_data;
   logic [DW-1:0] A, B, store_data;
   logic [2:0]    ALUOp;
   logic [RW-1:0] ex_dst;
   logic          ex_valid, ex_RegWrite, ex_MemRead;
   logic          ex_MemWrite, ex_MemToReg, load_use_stall;
   logic [TCW-1:0] bubble_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   id_ex_stage #(.DW(DW), .RW(RW), .CW(TCW)) dut (
      .CLK(CLK), .Reset(Reset), .hold(hold), .flush(flush),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_sa(id_sa),
      .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB),
      .id_ALUOp(id_ALUOp), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_MemToReg(id_MemToReg), .id_RegDst(id_RegDst),
      .exm_RegWrite(exm_RegWrite), .exm_rd(exm_rd),
      .exm_result(exm_result), .mwb_RegWrite(mwb_RegWrite),
      .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .A(A), .B(B), .ALUOp(ALUOp), .store_data(store_data),
      .ex_dst(ex_dst), .ex_valid(ex_valid),
      .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
      .load_use_stall(load_use_stall),
      .bubble_count(bubble_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic nop();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_sa = 0;
      id_ALUSrcA = 0; id_ALUSrcB = 0; id_ALUOp = 0;
      id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0;
      id_MemToReg = 0; id_RegDst = 0;
   endtask

   task automatic fwd_off();
      exm_RegWrite = 0; exm_rd = 0; exm_result = 0;
      mwb_RegWrite = 0; mwb_rd = 0; mwb_data = 0;
   endtask

   task automatic drive_lw();
      nop();
      id_valid = 1; id_rs = 1; id_rt = 9; id_MemRead = 1;
      id_RegWrite = 1; id_MemToReg = 1; id_ALUSrcB = 1; id_imm = 4;
   endtask

   task automatic drive_use();
      nop();
      id_valid = 1; id_rs = 9; id_rt = 2; id_rd = 10;
      id_RegDst = 1; id_RegWrite = 1; id_ALUOp = 3'b010;
   endtask

   initial begin
      Reset = 1; hold = 0; flush = 0;
      nop(); fwd_off();
      id_valid = 1; id_rs = 3; id_rt = 4; id_rs_data = 32'hdead;
      id_rt_data = 32'hbeef; id_ALUOp = 3'b111; id_RegWrite = 1;
      exm_RegWrite = 1; exm_rd = 3; exm_result = 32'h1234;
      cyc(); cyc();
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_store", store_data, 0);
      chk("rst_dst", {27'd0, ex_dst}, 0);
      chk("rst_valid", {31'd0, ex_valid}, 0);
      chk("rst_stall", {31'd0, load_use_stall}, 0);
      chk("rst_count", {30'd0, bubble_count}, 0);

      Reset = 0; fwd_off(); nop();
      id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3;
      id_rs_data = 5; id_rt_data = 3; id_ALUOp = 3'b001;
      id_RegWrite = 1; id_RegDst = 1;
      cyc();
      chk("cap_A", A, 5);
      chk("cap_B", B, 3);
      chk("cap_op", {29'd0, ALUOp}, 1);
      chk("cap_dst", {27'd0, ex_dst}, 3);
      chk("cap_rw", {31'd0, ex_RegWrite}, 1);

      nop();
      id_valid = 0; id_RegWrite = 1; id_MemRead = 1;
      cyc();
      chk("inv_rw", {31'd0, ex_RegWrite}, 0);
      chk("inv_mr", {31'd0, ex_MemRead}, 0);

      nop();
      id_valid = 1; id_rs = 8; id_rs_data = 32'h11;
      cyc();
      hold = 1; nop();
      exm_RegWrite = 1; exm_rd = 8; exm_result = 32'haaaa;
      mwb_RegWrite = 1; mwb_rd = 8; mwb_data = 32'h5555;
      #1 chk("fwd_exm", A, 32'haaaa);
      exm_RegWrite = 0;
      #1 chk("fwd_mwb", A, 32'h5555);
      exm_RegWrite = 1; exm_rd = 0; mwb_RegWrite = 0;
      #1 chk("fwd_none", A, 32'h11);
      cyc();
      chk("hold_A", A, 32'h11);
      hold = 0; fwd_off();

      drive_lw();
      cyc();
      drive_use();
      #1 chk("lu_stall", {31'd0, load_use_stall}, 1);
      chk("lu_dst", {27'd0, ex_dst}, 9);
      cyc();
      chk("lu_bub_valid", {31'd0, ex_valid}, 0);
      chk("lu_count1", {30'd0, bubble_count}, 1);
      chk("lu_stall_clr", {31'd0, load_use_stall}, 0);
      cyc();
      chk("lu_issue", {31'd0, ex_valid}, 1);
      chk("lu_op", {29'd0, ALUOp}, 3'b010);

      drive_lw();
      cyc();
      drive_use(); hold = 1;
      cyc();
      chk("lh_valid", {31'd0, ex_valid}, 1);
      chk("lh_mr", {31'd0, ex_MemRead}, 1);
      chk("lh_stall", {31'd0, load_use_stall}, 1);
      chk("lh_count", {30'd0, bubble_count}, 1);
      hold = 0;
      cyc();
      chk("lh_count2", {30'd0, bubble_count}, 2);
      chk("lh_bub", {31'd0, ex_valid}, 0);

      cyc();
      chk("fh_pre", {31'd0, ex_valid}, 1);
      flush = 1; hold = 1;
      cyc();
      chk("fh_valid", {31'd0, ex_valid}, 0);
      chk("fh_rw", {31'd0, ex_RegWrite}, 0);
      chk("fh_count", {30'd0, bubble_count}, 2);
      flush = 0; hold = 0;

      nop();
      id_valid = 1; id_ALUSrcA = 1; id_sa = 4; id_ALUSrcB = 1;
      id_imm = 32'hfffffff0; id_rt = 5; id_rt_data = 32'h99;
      id_MemWrite = 1;
      exm_RegWrite = 1; exm_rd = 5; exm_result = 7;
      mwb_RegWrite = 1; mwb_rd = 5; mwb_data = 32'h66;
      cyc();
      chk("imm_A", A, 4);
      chk("imm_B", B, 32'hfffffff0);
      chk("imm_store", store_data, 7);
      fwd_off();

      drive_lw(); cyc(); drive_use(); cyc();
      chk("sat_3", {30'd0, bubble_count}, 3);
      cyc();
      drive_lw(); cyc(); drive_use(); cyc();
      chk("sat_hold", {30'd0, bubble_count}, 3);
      chk("sat_bub", {31'd0, ex_valid}, 0);
      cyc();

      drive_lw(); cyc(); drive_use(); hold = 1;
      #1 chk("rs_pre", {31'd0, load_use_stall}, 1);
      Reset = 1;
      cyc();
      chk("rs_valid", {31'd0, ex_valid}, 0);
      chk("rs_count", {30'd0, bubble_count}, 0);
      chk("rs_stall", {31'd0, load_use_stall}, 0);
      Reset = 0; hold = 0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
